// File: rtl/double_cmp_arbiter.sv
// ---------------------------------------------------------------------------
// double_cmp_arbiter
//
// Shares one external double-precision comparator between NREQ requesters.
// A round-robin scheduler accepts one operand pair at a time and registers
// it onto cmp_a/cmp_b. It waits CMP_LATENCY cycles for the comparator and
// returns the 1-bit result to the granted requester with a stb/ack handshake.
//
// Ports
//   clk       clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   req_stb   per-requester operand valid
//   req_a     operand a, requester i at bits [64i+63:64i]
//   req_b     operand b, same packing
//   req_ack   one-cycle pulse: operands of requester i accepted
//   res_stb   result valid for requester i (held until res_ack[i])
//   res_z     result bit, valid while any res_stb bit is high
//   res_ack   result consumed by requester i
//   cmp_a     operand a to comparator (registered)
//   cmp_b     operand b to comparator (registered)
//   cmp_z     comparator result
//   busy      high while a transaction is in flight (WAIT or RESULT)
//   grant_id  index of the current or last granted requester
// ---------------------------------------------------------------------------
module double_cmp_arbiter #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int CMP_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_stb,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      res_stb,
    output logic                 res_z,
    input  logic [NREQ-1:0]      res_ack,
    output logic [63:0]          cmp_a,
    output logic [63:0]          cmp_b,
    input  logic                 cmp_z,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    // Wide enough to hold CMP_LATENCY; at least one bit so latency 0 works.
    localparam int CNTW = (CMP_LATENCY < 2) ? 1 : $clog2(CMP_LATENCY + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CNTW-1:0] cnt_reg;
    logic [IDW-1:0]  last_reg;

    // Unpacked per-requester views of the packed operand buses.
    logic [63:0] op_a [NREQ];
    logic [63:0] op_b [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[64*gi +: 64];
            assign op_b[gi] = req_b[64*gi +: 64];
        end
    endgenerate

    // Round-robin pick: search last+1, last+2, ... modulo NREQ.
    // The loop walks from the farthest candidate to the nearest, so the
    // last assignment that survives is the nearest set request.
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;

    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_stb[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= IDW'(NREQ - 1);
            req_ack   <= '0;
            res_stb   <= '0;
            res_z     <= 1'b0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            busy      <= 1'b0;
            grant_id  <= IDW'(NREQ - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        cmp_a     <= op_a[pick_idx];
                        cmp_b     <= op_b[pick_idx];
                        grant_id  <= pick_idx;
                        req_ack   <= ONE_HOT0 << pick_idx;
                        cnt_reg   <= CNTW'(CMP_LATENCY);
                        busy      <= 1'b1;
                        state_reg <= WAIT;
                    end
                end

                WAIT: begin
                    // The acceptance pulse lasts exactly one cycle.
                    req_ack <= '0;
                    if (cnt_reg == '0) begin
                        // Comparator output has settled for the held operands.
                        res_z     <= cmp_z;
                        res_stb   <= ONE_HOT0 << grant_id;
                        state_reg <= RESULT;
                    end else begin
                        cnt_reg <= cnt_reg - CNTW'(1);
                    end
                end

                RESULT: begin
                    // Only the granted requester can release the result;
                    // res_z keeps its value after the handshake.
                    if (res_ack[grant_id]) begin
                        res_stb   <= '0;
                        last_reg  <= grant_id;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_double_cmp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_double_cmp_arbiter
//
// Three instances of the arbiter with CMP_LATENCY = 1, 0 and 3, each driving
// a behavioural IEEE "less or equal" comparator with matching latency.
// Directed table vectors cover single transactions; hand-written sequences
// cover round robin, latency, result backpressure and reset during WAIT.
// ---------------------------------------------------------------------------
module tb_double_cmp_arbiter;

    localparam int N = 4;

    localparam logic [63:0] D_P1  = 64'h3FF0000000000000; //  1.0
    localparam logic [63:0] D_P2  = 64'h4000000000000000; //  2.0
    localparam logic [63:0] D_M3  = 64'hC008000000000000; // -3.0
    localparam logic [63:0] D_M1  = 64'hBFF0000000000000; // -1.0
    localparam logic [63:0] D_NZ  = 64'h8000000000000000; // -0.0
    localparam logic [63:0] D_PZ  = 64'h0000000000000000; // +0.0
    localparam logic [63:0] D_NAN = 64'h7FF8000000000000; //  NaN

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT with CMP_LATENCY = 1 ----------------
    logic            rst1;
    logic [N-1:0]    req_stb1, req_ack1, res_stb1, res_ack1;
    logic [64*N-1:0] req_a1, req_b1;
    logic            res_z1, cmp_z1, busy1;
    logic [63:0]     cmp_a1, cmp_b1;
    logic [1:0]      grant_id1;

    // ---------------- DUT with CMP_LATENCY = 0 ----------------
    logic            rst0;
    logic [N-1:0]    req_stb0, req_ack0, res_stb0, res_ack0;
    logic [64*N-1:0] req_a0, req_b0;
    logic            res_z0, cmp_z0, busy0;
    logic [63:0]     cmp_a0, cmp_b0;
    logic [1:0]      grant_id0;

    // ---------------- DUT with CMP_LATENCY = 3 ----------------
    logic            rst3;
    logic [N-1:0]    req_stb3, req_ack3, res_stb3, res_ack3;
    logic [64*N-1:0] req_a3, req_b3;
    logic            res_z3, cmp_z3, busy3;
    logic [63:0]     cmp_a3, cmp_b3;
    logic [1:0]      grant_id3;

    double_cmp_arbiter #(.NREQ(N), .IDW(2), .CMP_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .req_stb(req_stb1), .req_a(req_a1), .req_b(req_b1),
        .req_ack(req_ack1), .res_stb(res_stb1), .res_z(res_z1), .res_ack(res_ack1),
        .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_z(cmp_z1), .busy(busy1), .grant_id(grant_id1)
    );

    double_cmp_arbiter #(.NREQ(N), .IDW(2), .CMP_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst0), .req_stb(req_stb0), .req_a(req_a0), .req_b(req_b0),
        .req_ack(req_ack0), .res_stb(res_stb0), .res_z(res_z0), .res_ack(res_ack0),
        .cmp_a(cmp_a0), .cmp_b(cmp_b0), .cmp_z(cmp_z0), .busy(busy0), .grant_id(grant_id0)
    );

    double_cmp_arbiter #(.NREQ(N), .IDW(2), .CMP_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .req_stb(req_stb3), .req_a(req_a3), .req_b(req_b3),
        .req_ack(req_ack3), .res_stb(res_stb3), .res_z(res_z3), .res_ack(res_ack3),
        .cmp_a(cmp_a3), .cmp_b(cmp_b3), .cmp_z(cmp_z3), .busy(busy3), .grant_id(grant_id3)
    );

    // Behavioural IEEE-754 a <= b (NaN compares false, -0 == +0).
    function automatic logic fp_le(input logic [63:0] a, input logic [63:0] b);
        logic a_nan, b_nan;
        a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        if (a_nan || b_nan) return 1'b0;
        if (a[62:0] == 63'd0 && b[62:0] == 63'd0) return 1'b1;
        if (a[63] != b[63]) return a[63];
        if (!a[63]) return a[62:0] <= b[62:0];
        return a[62:0] >= b[62:0];
    endfunction

    // Comparator models with latency 0, 1 and 3.
    logic [2:0] pipe3;
    assign cmp_z0 = fp_le(cmp_a0, cmp_b0);
    always @(posedge clk) cmp_z1 <= fp_le(cmp_a1, cmp_b1);
    always @(posedge clk) pipe3 <= {pipe3[1:0], fp_le(cmp_a3, cmp_b3)};
    assign cmp_z3 = pipe3[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the latency-1 instance, single requester.
    task automatic run_one(input int idx, input logic [63:0] a, input logic [63:0] b,
                           input logic exp_z);
        logic [N-1:0] oh;
        oh = N'(1) << idx;
        req_a1 = '0;
        req_b1 = '0;
        req_a1[64*idx +: 64] = a;
        req_b1[64*idx +: 64] = b;
        req_stb1 = oh;
        tick();                                     // E0: grant edge
        check("vec_req_ack", req_ack1, oh);
        check("vec_grant_id", grant_id1, idx);
        check("vec_cmp_a", cmp_a1, a);
        check("vec_cmp_b", cmp_b1, b);
        check("vec_busy", busy1, 1);
        check("vec_res_stb_early", res_stb1, 0);
        req_stb1 = '0;
        tick();                                     // E0+1
        check("vec_req_ack_clear", req_ack1, 0);
        check("vec_res_stb_wait", res_stb1, 0);
        tick();                                     // E0+2: result visible
        check("vec_res_stb", res_stb1, oh);
        check("vec_res_z", res_z1, exp_z);
        res_ack1 = oh;
        tick();
        res_ack1 = '0;
        check("vec_res_stb_clear", res_stb1, 0);
        check("vec_busy_clear", busy1, 0);
        check("vec_res_z_hold", res_z1, exp_z);
        $display("[TB] txn req=%0d a=%h b=%h res_z=%b expect=%b", idx, a, b, res_z1, exp_z);
    endtask

    typedef struct {
        int          idx;
        logic [63:0] a;
        logic [63:0] b;
        logic        z;
    } vec_t;

    vec_t vecs [6];
    int   gcnt;
    int   gidx [5];
    int   gcyc [5];
    int   lat0, lat3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, D_P1,  D_P2, 1'b1};   //  1.0 <=  2.0
        vecs[1] = '{2, D_P2,  D_P1, 1'b0};   //  2.0 <=  1.0
        vecs[2] = '{1, D_M3,  D_M3, 1'b1};   // -3.0 <= -3.0
        vecs[3] = '{0, D_NAN, D_P1, 1'b0};   //  NaN <=  1.0
        vecs[4] = '{2, D_NZ,  D_PZ, 1'b1};   // -0.0 <= +0.0
        vecs[5] = '{3, D_M1,  D_P1, 1'b1};   // -1.0 <=  1.0

        rst1 = 1'b1; rst0 = 1'b1; rst3 = 1'b1;
        req_stb1 = '0; req_a1 = '0; req_b1 = '0; res_ack1 = '0;
        req_stb0 = '0; req_a0 = '0; req_b0 = '0; res_ack0 = '0;
        req_stb3 = '0; req_a3 = '0; req_b3 = '0; res_ack3 = '0;
        tick();
        tick();

        // Reset state
        check("rst_req_ack", req_ack1, 0);
        check("rst_res_stb", res_stb1, 0);
        check("rst_res_z", res_z1, 0);
        check("rst_cmp_a", cmp_a1, 0);
        check("rst_cmp_b", cmp_b1, 0);
        check("rst_busy", busy1, 0);
        check("rst_grant_id", grant_id1, 3);
        check("rst_grant_id_l0", grant_id0, 3);
        check("rst_grant_id_l3", grant_id3, 3);
        rst1 = 1'b0; rst0 = 1'b0; rst3 = 1'b0;
        tick();
        check("idle_no_ack", req_ack1, 0);

        // Table-driven single transactions; the last one leaves last = 3.
        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].z);
        end

        // Round robin with all requesters active and immediate result ack.
        for (int i = 0; i < N; i++) begin
            req_a1[64*i +: 64] = D_P1;
            req_b1[64*i +: 64] = D_P2;
        end
        req_stb1 = 4'hF;
        gcnt = 0;
        for (int c = 0; c < 80 && gcnt < 5; c++) begin
            tick();
            res_ack1 = res_stb1;
            if (req_ack1 != '0) begin
                check("rr_ack_onehot", $countones(req_ack1), 1);
                for (int k = 0; k < N; k++) begin
                    if (req_ack1[k]) gidx[gcnt] = k;
                end
                gcyc[gcnt] = c;
                gcnt++;
                if (gcnt == 5) req_stb1 = '0;
            end
        end
        check("rr_grant_count", gcnt, 5);
        for (int k = 0; k < gcnt; k++) begin
            check("rr_order", gidx[k], k % N);
            if (k > 0) check("rr_spacing", gcyc[k] - gcyc[k-1], 4);
            $display("[TB] txn rr grant %0d -> req %0d at cycle %0d", k, gidx[k], gcyc[k]);
        end
        for (int c = 0; c < 20 && busy1; c++) begin
            tick();
            res_ack1 = res_stb1;
        end
        res_ack1 = '0;
        check("rr_drain_busy", busy1, 0);

        // Result backpressure: last = 0, so requester 1 is granted.
        req_a1 = '0; req_b1 = '0;
        req_a1[64*1 +: 64] = D_P1;
        req_b1[64*1 +: 64] = D_P2;
        req_stb1 = 4'b0010;
        tick();
        check("bp_req_ack", req_ack1, 4'b0010);
        req_stb1 = '0;
        tick();
        tick();
        check("bp_res_stb", res_stb1, 4'b0010);
        req_a1[64*0 +: 64] = D_P2;
        req_b1[64*0 +: 64] = D_P1;
        req_stb1 = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            res_ack1 = (c % 2 == 0) ? 4'b1000 : 4'b0000;
            tick();
            check("bp_res_stb_hold", res_stb1, 4'b0010);
            check("bp_res_z_hold", res_z1, 1);
            check("bp_no_ack", req_ack1, 0);
            check("bp_busy", busy1, 1);
            check("bp_grant_id", grant_id1, 1);
        end
        res_ack1 = 4'b0010;
        tick();
        res_ack1 = '0;
        check("bp_release_stb", res_stb1, 0);
        check("bp_release_busy", busy1, 0);
        check("bp_release_z", res_z1, 1);
        $display("[TB] txn backpressure req=1 res_z=%b", res_z1);
        tick();
        check("bp_next_ack", req_ack1, 4'b0001);
        check("bp_next_grant", grant_id1, 0);
        check("bp_next_cmp_a", cmp_a1, D_P2);
        req_stb1 = '0;
        tick();
        tick();
        check("bp_next_res_stb", res_stb1, 4'b0001);
        check("bp_next_res_z", res_z1, 0);
        res_ack1 = 4'b0001;
        tick();
        res_ack1 = '0;
        $display("[TB] txn req=0 after backpressure res_z=%b", res_z1);

        // Reset during WAIT: last = 0, requester 3 is granted then aborted.
        req_a1 = '0; req_b1 = '0;
        req_a1[64*3 +: 64] = D_P1;
        req_b1[64*3 +: 64] = D_P2;
        req_stb1 = 4'b1000;
        tick();
        check("rw_req_ack", req_ack1, 4'b1000);
        check("rw_grant", grant_id1, 3);
        rst1 = 1'b1;
        req_a1[64*2 +: 64] = D_M3;
        req_b1[64*2 +: 64] = D_M1;
        req_stb1 = 4'b1100;
        tick();
        check("rw_req_ack_rst", req_ack1, 0);
        check("rw_res_stb_rst", res_stb1, 0);
        check("rw_res_z_rst", res_z1, 0);
        check("rw_cmp_a_rst", cmp_a1, 0);
        check("rw_cmp_b_rst", cmp_b1, 0);
        check("rw_busy_rst", busy1, 0);
        check("rw_grant_rst", grant_id1, 3);
        rst1 = 1'b0;
        tick();
        check("rw_regrant_ack", req_ack1, 4'b0100);
        check("rw_regrant_id", grant_id1, 2);
        check("rw_regrant_cmp_a", cmp_a1, D_M3);
        check("rw_no_stale_res", res_stb1, 0);
        req_stb1 = '0;
        tick();
        check("rw_wait_res", res_stb1, 0);
        tick();
        check("rw_res_stb", res_stb1, 4'b0100);
        check("rw_res_z", res_z1, 1);
        res_ack1 = 4'b0100;
        tick();
        res_ack1 = '0;
        check("rw_done_busy", busy1, 0);
        $display("[TB] txn reset-abort then req=2 res_z=%b", res_z1);

        // Latency sweep on the latency-0 and latency-3 instances.
        req_a0[63:0] = D_M3; req_b0[63:0] = D_M3;
        req_a3[63:0] = D_M3; req_b3[63:0] = D_M3;
        req_stb0 = 4'b0001;
        req_stb3 = 4'b0001;
        tick();
        check("lat0_req_ack", req_ack0, 4'b0001);
        check("lat3_req_ack", req_ack3, 4'b0001);
        req_stb0 = '0;
        req_stb3 = '0;
        lat0 = -1;
        lat3 = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (lat0 < 0 && res_stb0 != '0) begin
                lat0 = c;
                check("lat0_res_stb", res_stb0, 4'b0001);
                check("lat0_res_z", res_z0, 1);
                res_ack0 = 4'b0001;
            end
            if (lat3 < 0 && res_stb3 != '0) begin
                lat3 = c;
                check("lat3_res_stb", res_stb3, 4'b0001);
                check("lat3_res_z", res_z3, 1);
                res_ack3 = 4'b0001;
            end
        end
        res_ack0 = '0;
        res_ack3 = '0;
        check("lat0_cycles", lat0, 1);
        check("lat3_cycles", lat3, 4);
        check("lat0_busy_done", busy0, 0);
        check("lat3_busy_done", busy3, 0);
        $display("[TB] txn latency sweep lat0=%0d lat3=%0d", lat0, lat3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
